// File: rtl/cdb_complete_arbiter.sv
// cdb_complete_arbiter: round-robin selection of up to CDB_W completed FU
// results onto the registered common data bus, with per-FU stall back to the
// losers and branch squash/clear applied at capture and on the live CDB.
module cdb_complete_arbiter #(
  parameter int NUM_FU  = 4,
  parameter int CDB_W   = 2,
  parameter int XLEN    = 32,
  parameter int PREG_W  = 6,
  parameter int ROB_W   = 5,
  parameter int BMASK_W = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*XLEN-1:0]     fu_result,
  input  logic [NUM_FU*PREG_W-1:0]   fu_dest_preg,
  input  logic [NUM_FU*ROB_W-1:0]    fu_rob_idx,
  input  logic [NUM_FU*BMASK_W-1:0]  fu_b_mask,
  input  logic [1:0]                 rem_br_task,
  input  logic [BMASK_W-1:0]         rem_b_id,
  output logic [NUM_FU-1:0]          fu_stall,
  output logic [CDB_W-1:0]           cdb_valid,
  output logic [CDB_W*XLEN-1:0]      cdb_result,
  output logic [CDB_W*PREG_W-1:0]    cdb_preg,
  output logic [CDB_W*ROB_W-1:0]     cdb_rob_idx,
  output logic [CDB_W*BMASK_W-1:0]   cdb_b_mask
);

  localparam int         PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [1:0] BR_CLEAR  = 2'b01;
  localparam logic [1:0] BR_SQUASH = 2'b10;

  // True when the branch mask depends on the resolving branch.
  function automatic logic mask_hit(input logic [BMASK_W-1:0] m,
                                    input logic [BMASK_W-1:0] id);
    return |(m & id);
  endfunction

  // Drops the resolved branch bit from a mask when that branch is cleared.
  function automatic logic [BMASK_W-1:0] mask_clear(input logic [BMASK_W-1:0] m,
                                                    input logic [BMASK_W-1:0] id,
                                                    input logic [1:0]         br_task);
    if (br_task == BR_CLEAR && mask_hit(m, id))
      return m & ~id;
    return m;
  endfunction

  logic                        squash;
  logic [NUM_FU-1:0]           eligible;
  logic [NUM_FU-1:0]           granted;
  logic [PTR_W-1:0]            rr_ptr;
  logic [PTR_W-1:0]            rr_ptr_nxt;

  logic [CDB_W-1:0]            vld_nxt;
  logic [CDB_W*XLEN-1:0]       result_nxt;
  logic [CDB_W*PREG_W-1:0]     preg_nxt;
  logic [CDB_W*ROB_W-1:0]      rob_nxt;
  logic [CDB_W*BMASK_W-1:0]    bmask_nxt;

  logic [CDB_W-1:0]            vld_p1;
  logic [CDB_W*XLEN-1:0]       result_p1;
  logic [CDB_W*PREG_W-1:0]     preg_p1;
  logic [CDB_W*ROB_W-1:0]      rob_p1;
  logic [CDB_W*BMASK_W-1:0]    bmask_p1;

  assign squash = (rem_br_task == BR_SQUASH);

  // An FU competes only if it holds a result that is not being squashed now.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_FU; i++)
      eligible[i] = fu_valid[i] &
                    ~(squash & mask_hit(fu_b_mask[i*BMASK_W +: BMASK_W], rem_b_id));
  end

  // Round-robin scan from rr_ptr; the n-th grant found fills lane n.
  always_comb begin
    int               n_gnt;
    int               idx_i;
    logic [PTR_W-1:0] idx;
    granted    = '0;
    vld_nxt    = '0;
    result_nxt = '0;
    preg_nxt   = '0;
    rob_nxt    = '0;
    bmask_nxt  = '0;
    rr_ptr_nxt = rr_ptr;
    n_gnt      = 0;
    idx_i      = 0;
    idx        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NUM_FU)
        idx_i = idx_i - NUM_FU;
      idx = PTR_W'(idx_i);
      if (eligible[idx] && n_gnt < CDB_W) begin
        granted[idx] = 1'b1;
        for (int l = 0; l < CDB_W; l++) begin
          if (l == n_gnt) begin
            vld_nxt[l]                      = 1'b1;
            result_nxt[l*XLEN +: XLEN]      = fu_result[idx_i*XLEN +: XLEN];
            preg_nxt[l*PREG_W +: PREG_W]    = fu_dest_preg[idx_i*PREG_W +: PREG_W];
            rob_nxt[l*ROB_W +: ROB_W]       = fu_rob_idx[idx_i*ROB_W +: ROB_W];
            bmask_nxt[l*BMASK_W +: BMASK_W] =
              mask_clear(fu_b_mask[idx_i*BMASK_W +: BMASK_W], rem_b_id, rem_br_task);
          end
        end
        rr_ptr_nxt = (idx_i == NUM_FU - 1) ? '0 : PTR_W'(idx_i + 1);
        n_gnt      = n_gnt + 1;
      end
    end
  end

  // Eligible losers hold their result; squashed or idle FUs never stall.
  assign fu_stall = fu_valid & eligible & ~granted;

  // ---- stage p1: CDB output register, rewritten every cycle ----
  // Captures this cycle's winners and advances the round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      vld_p1    <= '0;
      result_p1 <= '0;
      preg_p1   <= '0;
      rob_p1    <= '0;
      bmask_p1  <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      vld_p1    <= vld_nxt;
      result_p1 <= result_nxt;
      preg_p1   <= preg_nxt;
      rob_p1    <= rob_nxt;
      bmask_p1  <= bmask_nxt;
    end
  end

  // Live squash/clear on lanes already broadcasting.
  always_comb begin
    cdb_valid  = '0;
    cdb_b_mask = '0;
    for (int l = 0; l < CDB_W; l++) begin
      cdb_valid[l] = vld_p1[l] &
                     ~(squash & mask_hit(bmask_p1[l*BMASK_W +: BMASK_W], rem_b_id));
      cdb_b_mask[l*BMASK_W +: BMASK_W] =
        mask_clear(bmask_p1[l*BMASK_W +: BMASK_W], rem_b_id, rem_br_task);
    end
  end

  assign cdb_result  = result_p1;
  assign cdb_preg    = preg_p1;
  assign cdb_rob_idx = rob_p1;

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Bench for cdb_complete_arbiter: directed scenarios followed by randomized
// FU traffic compared against a queue-based reference model.
module tb_cdb_complete_arbiter;

  localparam int NUM_FU  = 4;
  localparam int CDB_W   = 2;
  localparam int XLEN    = 32;
  localparam int PREG_W  = 6;
  localparam int ROB_W   = 5;
  localparam int BMASK_W = 4;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU*XLEN-1:0]    fu_result;
  logic [NUM_FU*PREG_W-1:0]  fu_dest_preg;
  logic [NUM_FU*ROB_W-1:0]   fu_rob_idx;
  logic [NUM_FU*BMASK_W-1:0] fu_b_mask;
  logic [1:0]                rem_br_task;
  logic [BMASK_W-1:0]        rem_b_id;
  logic [NUM_FU-1:0]         fu_stall;
  logic [CDB_W-1:0]          cdb_valid;
  logic [CDB_W*XLEN-1:0]     cdb_result;
  logic [CDB_W*PREG_W-1:0]   cdb_preg;
  logic [CDB_W*ROB_W-1:0]    cdb_rob_idx;
  logic [CDB_W*BMASK_W-1:0]  cdb_b_mask;

  cdb_complete_arbiter #(
    .NUM_FU(NUM_FU), .CDB_W(CDB_W), .XLEN(XLEN),
    .PREG_W(PREG_W), .ROB_W(ROB_W), .BMASK_W(BMASK_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .fu_valid(fu_valid), .fu_result(fu_result), .fu_dest_preg(fu_dest_preg),
    .fu_rob_idx(fu_rob_idx), .fu_b_mask(fu_b_mask),
    .rem_br_task(rem_br_task), .rem_b_id(rem_b_id),
    .fu_stall(fu_stall), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
    .cdb_preg(cdb_preg), .cdb_rob_idx(cdb_rob_idx), .cdb_b_mask(cdb_b_mask)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: pointer and registered lanes.
  int                 m_rr, n_rr;
  bit                 m_lv   [CDB_W];
  bit                 n_lv   [CDB_W];
  logic [XLEN-1:0]    m_res  [CDB_W];
  logic [XLEN-1:0]    n_res  [CDB_W];
  logic [PREG_W-1:0]  m_preg [CDB_W];
  logic [PREG_W-1:0]  n_preg [CDB_W];
  logic [ROB_W-1:0]   m_rob  [CDB_W];
  logic [ROB_W-1:0]   n_rob  [CDB_W];
  logic [BMASK_W-1:0] m_mask [CDB_W];
  logic [BMASK_W-1:0] n_mask [CDB_W];
  logic [NUM_FU-1:0]  m_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    for (int l = 0; l < CDB_W; l++) begin
      m_lv[l] = 0; m_res[l] = '0; m_preg[l] = '0; m_rob[l] = '0; m_mask[l] = '0;
    end
  endtask

  task automatic set_fu(input int i, input logic v, input logic [XLEN-1:0] r,
                        input logic [PREG_W-1:0] p, input logic [ROB_W-1:0] rb,
                        input logic [BMASK_W-1:0] m);
    fu_valid[i]                      = v;
    fu_result[i*XLEN +: XLEN]        = r;
    fu_dest_preg[i*PREG_W +: PREG_W] = p;
    fu_rob_idx[i*ROB_W +: ROB_W]     = rb;
    fu_b_mask[i*BMASK_W +: BMASK_W]  = m;
  endtask

  task automatic clear_fus();
    fu_valid = '0; fu_result = '0; fu_dest_preg = '0; fu_rob_idx = '0; fu_b_mask = '0;
    rem_br_task = 2'b00; rem_b_id = '0;
  endtask

  // At the falling edge: predict stall/CDB from the rules, compare, and
  // prepare the state the next rising edge should produce.
  task automatic eval_cycle();
    int                 hi[$];
    int                 lo[$];
    int                 all[$];
    int                 f;
    logic               sq, cl;
    logic [BMASK_W-1:0] mk, em;
    logic [CDB_W-1:0]   ev;
    @(negedge clock);
    sq = (rem_br_task == 2'b10);
    cl = (rem_br_task == 2'b01);
    hi = {}; lo = {};
    for (int i = 0; i < NUM_FU; i++) begin
      mk = fu_b_mask[i*BMASK_W +: BMASK_W];
      if (fu_valid[i] && !(sq && (mk & rem_b_id) != 0)) begin
        if (i >= m_rr) hi.push_back(i);
        else           lo.push_back(i);
      end
    end
    all = {hi, lo};
    m_stall = '0;
    for (int k = CDB_W; k < all.size(); k++) m_stall[all[k]] = 1'b1;

    chk("fu_stall", 64'(fu_stall), 64'(m_stall));
    ev = '0;
    for (int l = 0; l < CDB_W; l++)
      ev[l] = m_lv[l] && !(sq && (m_mask[l] & rem_b_id) != 0);
    chk("cdb_valid", 64'(cdb_valid), 64'(ev));
    for (int l = 0; l < CDB_W; l++) begin
      if (ev[l]) begin
        em = cl ? (m_mask[l] & ~rem_b_id) : m_mask[l];
        chk($sformatf("lane%0d_result", l), 64'(cdb_result[l*XLEN +: XLEN]), 64'(m_res[l]));
        chk($sformatf("lane%0d_preg", l), 64'(cdb_preg[l*PREG_W +: PREG_W]), 64'(m_preg[l]));
        chk($sformatf("lane%0d_rob", l), 64'(cdb_rob_idx[l*ROB_W +: ROB_W]), 64'(m_rob[l]));
        chk($sformatf("lane%0d_bmask", l), 64'(cdb_b_mask[l*BMASK_W +: BMASK_W]), 64'(em));
      end
    end

    for (int l = 0; l < CDB_W; l++) begin
      n_lv[l] = (l < all.size());
      n_res[l] = '0; n_preg[l] = '0; n_rob[l] = '0; n_mask[l] = '0;
      if (n_lv[l]) begin
        f = all[l];
        mk = fu_b_mask[f*BMASK_W +: BMASK_W];
        n_res[l]  = fu_result[f*XLEN +: XLEN];
        n_preg[l] = fu_dest_preg[f*PREG_W +: PREG_W];
        n_rob[l]  = fu_rob_idx[f*ROB_W +: ROB_W];
        n_mask[l] = cl ? (mk & ~rem_b_id) : mk;
      end
    end
    if (all.size() == 0)          n_rr = m_rr;
    else if (all.size() < CDB_W)  n_rr = (all[all.size()-1] + 1) % NUM_FU;
    else                          n_rr = (all[CDB_W-1] + 1) % NUM_FU;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    if (!reset_n) model_reset();
    else begin
      m_rr = n_rr;
      for (int l = 0; l < CDB_W; l++) begin
        m_lv[l] = n_lv[l]; m_res[l] = n_res[l]; m_preg[l] = n_preg[l];
        m_rob[l] = n_rob[l]; m_mask[l] = n_mask[l];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset_n = 1'b0;
    clear_fus();
    m_stall = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_result", 64'(cdb_result), 64'd0);
    chk("rst_preg", 64'(cdb_preg), 64'd0);
    chk("rst_rob", 64'(cdb_rob_idx), 64'd0);
    chk("rst_bmask", 64'(cdb_b_mask), 64'd0);
    reset_n = 1'b1;

    // Squash at input: FU1 killed, FUs 0 and 3 win.
    set_fu(0, 1'b1, 32'hA0, 6'd5, 5'd10, 4'b0000);
    set_fu(1, 1'b1, 32'hB1, 6'd6, 5'd11, 4'b0010);
    set_fu(3, 1'b1, 32'hD3, 6'd8, 5'd13, 4'b1000);
    rem_br_task = 2'b10; rem_b_id = 4'b0010;
    eval_cycle();
    chk("sqin_stall", 64'(fu_stall), 64'd0);
    advance();
    clear_fus();
    eval_cycle();
    chk("sqin_valid", 64'(cdb_valid), 64'b11);
    chk("sqin_rob0", 64'(cdb_rob_idx[4:0]), 64'd10);
    chk("sqin_rob1", 64'(cdb_rob_idx[9:5]), 64'd13);
    advance();

    // Single result from FU2.
    set_fu(2, 1'b1, 32'h1234, 6'd7, 5'd3, 4'b0000);
    eval_cycle();
    chk("single_stall", 64'(fu_stall), 64'd0);
    advance();
    clear_fus();
    eval_cycle();
    chk("single_valid", 64'(cdb_valid), 64'b01);
    chk("single_result", 64'(cdb_result[31:0]), 64'h1234);
    chk("single_preg", 64'(cdb_preg[5:0]), 64'd7);
    chk("single_rob", 64'(cdb_rob_idx[4:0]), 64'd3);
    advance();

    // Squash of a lane already on the CDB.
    set_fu(0, 1'b1, 32'h55, 6'd1, 5'd20, 4'b0100);
    set_fu(1, 1'b1, 32'h66, 6'd2, 5'd21, 4'b0000);
    eval_cycle();
    advance();
    clear_fus();
    rem_br_task = 2'b10; rem_b_id = 4'b0100;
    eval_cycle();
    chk("sqcdb_valid", 64'(cdb_valid), 64'b10);
    advance();

    // Clear during capture.
    clear_fus();
    set_fu(0, 1'b1, 32'h77, 6'd3, 5'd22, 4'b0110);
    rem_br_task = 2'b01; rem_b_id = 4'b0010;
    eval_cycle();
    advance();
    clear_fus();
    eval_cycle();
    chk("clr_bmask", 64'(cdb_b_mask[3:0]), 64'b0100);
    chk("clr_valid", 64'(cdb_valid[0]), 64'd1);
    advance();

    // Mid-stream reset, then fairness with all FUs held valid.
    for (int i = 0; i < NUM_FU; i++)
      set_fu(i, 1'b1, 32'h100 + i, 6'(i + 1), 5'(i + 1), 4'b0000);
    eval_cycle();
    advance();
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(cdb_valid), 64'd0);
    chk("mrst_result", 64'(cdb_result), 64'd0);
    model_reset();
    advance();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      eval_cycle();
      chk($sformatf("rr_stall%0d", c), 64'(fu_stall), (c % 2 == 0) ? 64'b1100 : 64'b0011);
      advance();
    end

    // Randomized traffic; stalled FUs hold their result.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!m_stall[i]) begin
          if ($urandom_range(9) < 6)
            set_fu(i, 1'b1, $urandom, 6'($urandom_range(63)), 5'($urandom_range(31)),
                   4'($urandom_range(15)));
          else
            fu_valid[i] = 1'b0;
        end
      end
      r = int'($urandom_range(9));
      rem_br_task = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : 2'b10;
      rem_b_id = 4'b0001 << $urandom_range(3);
      eval_cycle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_complete_arbiter.md
# cdb_complete_arbiter

Completion-side consumer of the functional-unit output registers. Each cycle it selects up to CDB_W valid FU results by round-robin and registers them onto the common data bus (CDB) for the ROB, reservation stations and physical register file. It returns a per-FU stall so that losing FUs hold their results. Branch squash and clear are applied both to FU results in flight and to the CDB output register.

## Interface

Parameters:
- NUM_FU, 4, number of functional units feeding the arbiter.
- CDB_W, 2, number of CDB broadcast lanes; 1 ≤ CDB_W ≤ NUM_FU.
- XLEN, 32, result width.
- PREG_W, 6, physical register tag width. Tag 0 means no register write; the result is still broadcast.
- ROB_W, 5, ROB index width.
- BMASK_W, 4, branch mask width.

Ports (vectors are packed with FU or lane 0 in the LSBs):
- clock, in, 1, rising-edge clock.
- reset_n, in, 1, asynchronous active-low reset.
- fu_valid, in, NUM_FU, FU holds a completed result (the FU's data_ready).
- fu_result, in, NUM_FU*XLEN, result per FU.
- fu_dest_preg, in, NUM_FU*PREG_W, destination tag per FU.
- fu_rob_idx, in, NUM_FU*ROB_W, ROB entry per FU.
- fu_b_mask, in, NUM_FU*BMASK_W, branch mask per FU.
- rem_br_task, in, 2, branch resolution task: 2'b00 NOTHING, 2'b01 CLEAR, 2'b10 SQUASH.
- rem_b_id, in, BMASK_W, one-hot resolved branch bit.
- fu_stall, out, NUM_FU, combinational; the FU must hold its result.
- cdb_valid, out, CDB_W, lane carries a result.
- cdb_result, out, CDB_W*XLEN.
- cdb_preg, out, CDB_W*PREG_W.
- cdb_rob_idx, out, CDB_W*ROB_W.
- cdb_b_mask, out, CDB_W*BMASK_W.

## Operation

- **Hit definition.** hit(m) = (m & rem_b_id) != 0.
- **Eligibility.** FU i is eligible if fu_valid[i] is set and not (rem_br_task == SQUASH and hit(fu_b_mask[i])).
- **Grant.** Scan eligible FUs in order rr_ptr, rr_ptr+1, …, wrapping mod NUM_FU. The first CDB_W FUs found are granted.
  - Lanes are filled in scan order: the first grant goes to lane 0.
  - Unfilled lanes capture valid = 0.
- **Stall.**
  - fu_stall[i] = fu_valid[i] & eligible[i] & ~granted[i].
  - A squashed FU sees stall 0 and clears itself.
  - An FU that is not valid sees stall 0.
- **Capture.** Each granted lane registers result, preg, rob_idx and b_mask.
  - If rem_br_task == CLEAR and the mask hits, the captured b_mask has the rem_b_id bit cleared.
- **Output register.** It is overwritten every cycle; there is no hold. The CDB has no back-pressure.
- **Squash of a broadcast lane.** cdb_valid[l] = reg_valid[l] & ~(rem_br_task == SQUASH & hit(reg_b_mask[l])).
  - This output is combinational.
  - The other lane fields are still driven but must be ignored.
- **Clear on a broadcast lane.** cdb_b_mask[l] shows the register value with the rem_b_id bit cleared when the task is CLEAR and the mask hits.
- **Round-robin pointer.**
  - After a cycle with at least one grant: rr_ptr <= (index of the last granted FU + 1) mod NUM_FU.
  - After a cycle with no grant: rr_ptr is unchanged.
- **Reset (reset_n low).** Takes effect immediately, including mid-operation.
  - rr_ptr = 0.
  - All lane registers are 0, so cdb_valid = 0 and every CDB field is 0.
  - fu_stall stays combinational from its inputs.

## Timing

- **Latency.** An FU result valid in cycle k and granted in cycle k appears on the CDB in cycle k+1.
- **Handshake.** stall = 0 while valid is set means the arbiter has accepted the result in cycle k. The FU may drop or replace it at the cycle-k edge.
- **Throughput.** Up to CDB_W results per cycle.
- **Starvation bound.** A continuously valid, unsquashed FU is granted within ceil(NUM_FU/CDB_W) cycles.
- **Simultaneous SQUASH and capture.** A squashed FU is never captured. A squash also kills matching lanes already on the CDB in the same cycle.
- **Simultaneous CLEAR and capture.** The captured mask is already cleared.
- **Combinational paths.** Inputs to fu_stall and to cdb_valid are combinational. No path runs from an output back to an input.
- **Reset timing.** Reset deassertion is synchronized externally. The first grant can occur in the cycle after reset_n rises.

## Test plan

- **Reset.** Assert reset_n = 0 mid-stream with lanes valid. Required: cdb_valid = 0 immediately and rr_ptr = 0, so that afterwards, with all 4 FUs valid, FUs 0 and 1 are granted first.
- **Single result.** FU2 valid with result 0x1234, preg 7, rob 3. Required: fu_stall = 0; the next cycle shows lane0 valid with 0x1234/7/3 and lane1 invalid.
- **Round-robin fairness.** All 4 FUs held valid (losers held by stall).
  - Cycle 0: FUs 0 and 1 granted; fu_stall = 4'b1100.
  - Cycle 1: FUs 2 and 3 granted; fu_stall = 4'b0011.
  - The pattern alternates every cycle.
- **Squash at input.** rem_b_id = 4'b0010, SQUASH; FU1 b_mask = 4'b0010; FUs 0, 1, 3 valid with rr_ptr = 0. Required: FUs 0 and 3 granted; fu_stall[1] = 0; FU1 never appears on the CDB.
- **Squash on the CDB.** A lane holds b_mask 4'b0100 and SQUASH with rem_b_id = 4'b0100 arrives. Required: that cdb_valid bit is 0 in the same cycle; the other lane, with mask 0, stays valid.
- **Clear.** FU0 b_mask = 4'b0110 is captured during CLEAR with rem_b_id = 4'b0010. Required: the next cycle cdb_b_mask = 4'b0100 and cdb_valid = 1.
